effect_switch_sequencer: RTL

Click-free effect selector between the effect filters and the audio DAC serializer. It takes the raw effect-select switches and the five candidate sample streams, and changes the active effect only at DAC frame boundaries. Each change is a fade-out, source swap, fade-in gain ramp. Its registered output feeds the DAC data input, replacing the current combinational selection mux.

---
 rtl/effect_switch_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/effect_switch_sequencer.sv
// Click-free effect selector: swaps the DAC source only at frame ticks, with a
// fade-out/swap/fade-in gain ramp when EFFECT_RAMP_EN is defined (hard cut otherwise).
module effect_switch_sequencer #(
  parameter int unsigned RAMP_LOG2 = 6
) (
  input  logic        AUD_BCLK,
  input  logic        rst,
  input  logic        AUD_DACLRCK,
  input  logic [3:0]  sel_req,
  input  logic [31:0] dry_in,
  input  logic [31:0] echo_in,
  input  logic [31:0] hpf_in,
  input  logic [31:0] lpf_in,
  input  logic [31:0] mid_in,
  output logic [31:0] dac_data,
  output logic [2:0]  sel_active,
  output logic        busy
);

  localparam int unsigned GW = RAMP_LOG2 + 1;
  localparam int unsigned PW = GW + 17;
  localparam logic [GW-1:0] GainMax = {1'b1, {RAMP_LOG2{1'b0}}};

  logic [3:0]    sel_s1_q, sel_s2_q;
  logic          lrck_q;
  logic          tick;
  logic [2:0]    target;
  logic [2:0]    sel_q, sel_d;
  logic [31:0]   dac_q, dac_d;
  logic [31:0]   src;
  logic [GW-1:0] gain_cur;

  // Signed lane times unsigned gain; gain never exceeds 2^RAMP_LOG2, so no overflow.
  function automatic logic [15:0] scale_lane(input logic [15:0] s, input logic [GW-1:0] g);
    logic signed [PW-1:0] a, b, p;
    a = {{(PW-16){s[15]}}, s};
    b = {{(PW-GW){1'b0}}, g};
    p = a * b;
    p = p >>> RAMP_LOG2;
    return p[15:0];
  endfunction

  assign tick = AUD_DACLRCK & ~lrck_q;

  always_comb begin
    case (sel_s2_q)
      4'b1000: target = 3'd1;
      4'b0100: target = 3'd2;
      4'b0010: target = 3'd3;
      4'b0001: target = 3'd4;
      default: target = 3'd0;
    endcase
  end

  always_comb begin
    case (sel_q)
      3'd1:    src = echo_in;
      3'd2:    src = hpf_in;
      3'd3:    src = lpf_in;
      3'd4:    src = mid_in;
      default: src = dry_in;
    endcase
  end

  // Output uses the source and gain in force before this tick's update.
  always_comb begin
    dac_d = dac_q;
    if (tick) begin
      dac_d = {scale_lane(src[31:16], gain_cur), scale_lane(src[15:0], gain_cur)};
    end
  end

  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      sel_s1_q <= 4'b0;
      sel_s2_q <= 4'b0;
      lrck_q   <= 1'b0;
      sel_q    <= 3'd0;
      dac_q    <= 32'b0;
    end else begin
      sel_s1_q <= sel_req;
      sel_s2_q <= sel_s1_q;
      lrck_q   <= AUD_DACLRCK;
      sel_q    <= sel_d;
      dac_q    <= dac_d;
    end
  end

`ifdef EFFECT_RAMP_EN
  typedef enum logic [1:0] {StIdle, StFadeOut, StFadeIn} state_e;

  localparam logic [GW-1:0] GainOne = {{RAMP_LOG2{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [GW-1:0] gain_q, gain_d;

  assign gain_cur = gain_q;
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    sel_d   = sel_q;
    if (tick) begin
      case (state_q)
        StIdle: begin
          if (target != sel_q) begin
            state_d = StFadeOut;
            gain_d  = GainMax - GainOne;
          end
        end
        StFadeOut: begin
          if (target == sel_q) begin
            state_d = StFadeIn;
            gain_d  = gain_q + GainOne;
          end else if (gain_q == '0) begin
            // Swap takes whatever target is current now, not the one that started the fade.
            sel_d   = target;
            gain_d  = GainOne;
            state_d = StFadeIn;
          end else begin
            gain_d  = gain_q - GainOne;
          end
        end
        StFadeIn: begin
          if (gain_q == GainMax) begin
            state_d = StIdle;
          end else begin
            gain_d  = gain_q + GainOne;
          end
        end
        default: begin
          state_d = StIdle;
          gain_d  = GainMax;
        end
      endcase
    end
  end

  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gain_q  <= GainMax;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end
`else
  assign gain_cur = GainMax;
  assign busy     = 1'b0;

  always_comb begin
    sel_d = sel_q;
    if (tick) begin
      sel_d = target;
    end
  end
`endif

  assign dac_data   = dac_q;
  assign sel_active = sel_q;

endmodule
